// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw asynchronous input and commits a new
// level only after DEBOUNCE_CYCLES consecutive qualified samples of it.
// Produces a registered clean level, single-cycle rise/fall pulses, a busy
// flag while a candidate transition is being qualified, and an optional
// abort counter enabled by defining DEBOUNCE_GLITCH_COUNT_EN.
module input_debouncer #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  input  logic       sample_en,
  output logic       sig_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    ARM_HIGH    = 2'b01,
    STABLE_HIGH = 2'b10,
    ARM_LOW     = 2'b11
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   s;
  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;
  logic [CW-1:0]          cnt_inc;
  logic                   commit_rise;
  logic                   commit_fall;
  logic                   abort;

  // Synchroniser chain: shifts every clock, independent of sample_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign s       = sync_chain[SYNC_STAGES-1];
  assign cnt_inc = cnt + CNT_ONE;

  // FSM state and qualification counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: arm on a new level, count matching samples, commit or abort.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    abort       = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (sample_en && s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next  = STABLE_HIGH;
            commit_rise = 1'b1;
          end else begin
            state_next = ARM_HIGH;
            cnt_next   = CNT_ONE;
          end
        end else begin
          state_next = STABLE_LOW;
        end
      end
      ARM_HIGH: begin
        if (sample_en) begin
          if (s) begin
            if (cnt_inc == CNT_TARGET) begin
              state_next  = STABLE_HIGH;
              cnt_next    = CNT_ZERO;
              commit_rise = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = STABLE_LOW;
            cnt_next   = CNT_ZERO;
            abort      = 1'b1;
          end
        end else begin
          state_next = ARM_HIGH;
        end
      end
      STABLE_HIGH: begin
        if (sample_en && !s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next  = STABLE_LOW;
            commit_fall = 1'b1;
          end else begin
            state_next = ARM_LOW;
            cnt_next   = CNT_ONE;
          end
        end else begin
          state_next = STABLE_HIGH;
        end
      end
      ARM_LOW: begin
        if (sample_en) begin
          if (!s) begin
            if (cnt_inc == CNT_TARGET) begin
              state_next  = STABLE_LOW;
              cnt_next    = CNT_ZERO;
              commit_fall = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = STABLE_HIGH;
            cnt_next   = CNT_ZERO;
            abort      = 1'b1;
          end
        end else begin
          state_next = ARM_LOW;
        end
      end
      default: begin
        state_next = RESET_STATE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Registered outputs: level and pulses change on the commit edge, busy tracks ARM states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out    <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (commit_rise) begin
        sig_out <= 1'b1;
      end else if (commit_fall) begin
        sig_out <= 1'b0;
      end else begin
        sig_out <= sig_out;
      end
      rise_pulse <= commit_rise;
      fall_pulse <= commit_fall;
      busy       <= (state_next == ARM_HIGH) || (state_next == ARM_LOW);
    end
  end

`ifdef DEBOUNCE_GLITCH_COUNT_EN
  // Saturating count of aborted candidate transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 8'd0;
    end else if (abort && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end else begin
      glitch_cnt <= glitch_cnt;
    end
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign glitch_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: a default instance and a
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance share the stimulus and are
// compared every cycle against a run-length reference model.
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_in = 1'b0;
  logic       sample_en = 1'b1;
  logic       out0, rise0, fall0, busy0;
  logic       out1, rise1, fall1, busy1;
  logic [7:0] glc0, glc1;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  input_debouncer u_dut0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sample_en(sample_en),
    .sig_out(out0), .rise_pulse(rise0), .fall_pulse(fall0), .busy(busy0),
    .glitch_cnt(glc0)
  );

  input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sample_en(sample_en),
    .sig_out(out1), .rise_pulse(rise1), .fall_pulse(fall1), .busy(busy1),
    .glitch_cnt(glc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // s seen at edge n is sig_in sampled SYNC_STAGES edges earlier (reset level
  // until that many edges have passed). The level commits once the run of
  // consecutive qualified samples differing from it reaches DEBOUNCE_CYCLES;
  // a qualified sample matching the level ends a non-empty run as a glitch.
  int   sd[2] = '{2, 3};
  int   dd[2] = '{16, 1};
  bit   hist[8];
  int   eds = 0;
  bit   lvl[2] = '{1'b0, 1'b0};
  int   run[2] = '{0, 0};
  bit   rp[2] = '{1'b0, 1'b0};
  bit   fp[2] = '{1'b0, 1'b0};
  int   gl[2] = '{0, 0};

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        eds = 0;
        for (int i = 0; i < 2; i++) begin
          lvl[i] = 1'b0; run[i] = 0; rp[i] = 1'b0; fp[i] = 1'b0; gl[i] = 0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          bit su;
          su = (eds >= sd[i]) ? hist[sd[i]-1] : 1'b0;
          rp[i] = 1'b0;
          fp[i] = 1'b0;
          if (sample_en) begin
            if (su != lvl[i]) begin
              run[i]++;
              if (run[i] == dd[i]) begin
                lvl[i] = su;
                run[i] = 0;
                if (su) rp[i] = 1'b1;
                else    fp[i] = 1'b1;
              end
            end else if (run[i] > 0) begin
              run[i] = 0;
              if (gl[i] < 255) gl[i]++;
            end
          end
        end
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sig_in;
        if (eds < 100) eds++;
      end
    end
  end

  function automatic int exp_gl(input int v);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("d0_out",   out0,  lvl[0]);
    check("d0_rise",  rise0, rp[0]);
    check("d0_fall",  fall0, fp[0]);
    check("d0_busy",  busy0, run[0] > 0);
    check("d0_glc",   glc0,  exp_gl(gl[0]));
    check("d1_out",   out1,  lvl[1]);
    check("d1_rise",  rise1, rp[1]);
    check("d1_fall",  fall1, fp[1]);
    check("d1_busy",  busy1, run[1] > 0);
    check("d1_glc",   glc1,  exp_gl(gl[1]));
  end

  // ---------------- stimulus ----------------
  initial begin
    int rises;
    int mode;
    int len;

    // Reset with sig_in held high: no commit, no pulses.
    rst_n = 1'b0; sig_in = 1'b1; sample_en = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_out", out0, 1'b0);
    check("rst_rise", rise0, 1'b0);
    rst_n = 1'b1;

    // Latency from release: sig_out rises after edge 17, pulse in cycle 18.
    repeat (17) @(negedge clk);
    check("lat_pre_out", out0, 1'b0);
    check("lat_busy", busy0, 1'b1);
    @(negedge clk);
    check("lat_out", out0, 1'b1);
    check("lat_rise", rise0, 1'b1);
    @(negedge clk);
    check("lat_rise_end", rise0, 1'b0);

    // Clean fall.
    sig_in = 1'b0;
    repeat (17) @(negedge clk);
    check("fall_pre_out", out0, 1'b1);
    @(negedge clk);
    check("fall_out", out0, 1'b0);
    check("fall_pulse", fall0, 1'b1);
    repeat (4) @(negedge clk);

    // Bounce: 5 high, 3 low, then steady high -> one abort, one rise.
    rises = 0;
    sig_in = 1'b1; repeat (5) @(negedge clk);
    sig_in = 1'b0; repeat (3) @(negedge clk);
    check("bounce_glc", glc0, exp_gl(1));
    sig_in = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (rise0) rises++;
    end
    check("bounce_rises", rises, 1);
    check("bounce_out", out0, 1'b1);

    // Sparse sampling: every 4th clock, steady low then steady high.
    sig_in = 1'b0;
    for (int k = 0; k < 80; k++) begin
      sample_en = (k % 4 == 0);
      @(negedge clk);
    end
    check("sparse_low", out0, 1'b0);
    sig_in = 1'b1;
    for (int k = 0; k < 56; k++) begin
      sample_en = (k % 4 == 0);
      @(negedge clk);
    end
    check("sparse_pre", out0, 1'b0);
    for (int k = 56; k < 80; k++) begin
      sample_en = (k % 4 == 0);
      @(negedge clk);
    end
    check("sparse_post", out0, 1'b1);
    sample_en = 1'b1;

    // Reset while qualifying a rise with cnt=10.
    sig_in = 1'b0;
    repeat (25) @(negedge clk);
    sig_in = 1'b1;
    begin
      int k;
      for (k = 0; k < 40 && run[0] != 10; k++) @(negedge clk);
      check("arm_reach_timeout", k < 40, 1'b1);
    end
    check("arm_busy", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arm_rst_busy", busy0, 1'b0);
    check("arm_rst_out", out0, 1'b0);
    check("arm_rst_rise", rise0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arm_release_rise", rise0, 1'b0);
    repeat (20) @(negedge clk);
    check("arm_requal", out0, 1'b1);

    // 300 glitches toward a high level from low -> counter saturation.
    sig_in = 1'b0;
    repeat (25) @(negedge clk);
    for (int g = 0; g < 300; g++) begin
      sig_in = 1'b1; repeat (4) @(negedge clk);
      sig_in = 1'b0; repeat (4) @(negedge clk);
    end
    check("sat_glc", glc0, exp_gl(255));
    check("sat_out", out0, 1'b0);

    // Random bouncy input with mixed sampling patterns.
    for (int seg = 0; seg < 150; seg++) begin
      sig_in = ~sig_in;
      len = $urandom_range(1, 24);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < len; k++) begin
        case (mode)
          0: sample_en = 1'b1;
          1: sample_en = 1'($urandom_range(0, 1));
          default: sample_en = (k % 4 == 0);
        endcase
        @(negedge clk);
      end
    end
    sample_en = 1'b1;
    repeat (25) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
